lcd_driver_4_digit: RTL and testbench
=====================================

# lcd_driver_4_digit

Four-digit display driver for the alarm-clock datapath. It selects one of three 4-digit BCD time sources: alarm time, current time, or key-entry buffer. It converts each digit to an 8-bit ASCII code for the LCD and raises `sound_a` when current time equals alarm time. It sits between the timegen/alarm-register/key-register blocks and the LCD pins. All outputs are registered.

## Interface
- No parameters.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `alarm_time_ms_hr`, `alarm_time_ls_hr`, `alarm_time_ms_min`, `alarm_time_ls_min`  in  4 each  stored alarm time, BCD.
- `current_time_ms_hr`, `current_time_ls_hr`, `current_time_ms_min`, `current_time_ls_min`  in  4 each  running clock time, BCD.
- `key_ms_hr`, `key_ls_hr`, `key_ms_min`, `key_ls_min`  in  4 each  key-entry buffer, BCD.
- `show_a`  in  1  select alarm time for display.
- `show_current_time`  in  1  select current time for display.
- `display_ms_hr`, `display_ls_hr`, `display_ms_min`, `display_ls_min`  out  8 each  ASCII code per LCD digit.
- `sound_a`  out  1  alarm-match indication.

## Operation
- Source select, per clock:
  - `show_a`=1 selects alarm time. `show_a` has priority when both selects are 1.
  - Otherwise `show_current_time`=1 selects current time.
  - Otherwise the key buffer is selected.
- Digit encode, applied to each selected 4-bit digit independently:
  - Values 0..9 map to 8'h30..8'h39 (`'0'`..`'9'`).
  - Values 10..15 map to 8'h21 (`'!'`, error glyph).
- Match detect: `sound_a` is 1 iff all four current-time digits equal the corresponding alarm-time digits.
  - Compare on raw 4-bit values, including non-BCD codes.
  - The compare is independent of `show_a`, `show_current_time` and the key inputs.
- No arithmetic and no width extension. Inputs are only compared and encoded.

## Timing
- All five outputs are registered. Latency is 1 clock from input change to output.
- Inputs are sampled at the rising edge. The output reflects that edge's inputs until the next edge.
- Reset (synchronous, `reset`=1 at a rising edge):
  - All `display_*` outputs = 8'h20 (space).
  - `sound_a` = 0.
- Reset dominates all inputs. On the first edge with `reset`=0, outputs take normal encoded values.
- Select changes take effect at the next edge. There is no glitch or intermediate value visible on outputs.
- A sustained match holds `sound_a` high every cycle. It is a level, not a pulse.
- Mismatch clears `sound_a` at the next edge.

## Configuration
- Macro: `LCD_DRIVER_BLANK_LEADING_ZERO_EN`.
- Defined: when the selected `ms_hr` digit is 0, `display_ms_hr` = 8'h20 (space) instead of 8'h30. All other digits are unaffected.
- Undefined: `ms_hr` is encoded like every other digit (0 maps to 8'h30).

## Structure
- Package `lcd_driver_pkg` holds:
  - ASCII constants: `ASCII_ZERO`=8'h30, `ASCII_ERROR`=8'h21, `ASCII_SPACE`=8'h20.
  - A packed 4-digit time struct (ms_hr, ls_hr, ms_min, ls_min), 4 bits each.
- One sub-module, `lcd_digit_encode`: combinational 4-bit BCD to 8-bit ASCII encoder with error glyph. It is instantiated four times.
- Top level contains the source mux, match comparator, leading-zero option and output registers.

## Test plan
- Reset: assert `reset` for 2 cycles with arbitrary inputs. Expect all `display_*` = 8'h20 and `sound_a`=0. After release, key=0,0,0,0 and selects 0 give displays 8'h30 ×4 one cycle later.
- Alarm display: alarm=1,2,3,4, current=0,0,0,0, `show_a`=1. Expect displays 8'h31,8'h32,8'h33,8'h34 and `sound_a`=0.
- Match: current=1,2,3,4 = alarm, `show_a`=0, `show_current_time`=1. Expect displays 8'h31..8'h34 and `sound_a`=1 at the next edge. Then change current to 5,6,7,8: expect displays 8'h35..8'h38 and `sound_a`=0 one cycle later.
- Priority/default: `show_a`=`show_current_time`=1 shows alarm digits. Both 0 with key=9,8,7,6 shows 8'h39,8'h38,8'h37,8'h36.
- Error glyph: key_ls_min=4'hA, others 0, selects 0. Expect `display_ls_min`=8'h21.
- Macro: with `LCD_DRIVER_BLANK_LEADING_ZERO_EN` and key=0,5,0,0, expect `display_ms_hr`=8'h20. Without the macro, expect 8'h30.

Source files
------------

// File: rtl/lcd_driver_pkg.sv
// lcd_driver_pkg
//   Shared constants and types for the four-digit LCD driver.
//   - ASCII codes used on the LCD: digit base, error glyph, blank.
//   - time_t: packed 4-digit BCD time (ms_hr, ls_hr, ms_min, ls_min).
package lcd_driver_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ERROR = 8'h21;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef struct packed {
    logic [3:0] ms_hr;
    logic [3:0] ls_hr;
    logic [3:0] ms_min;
    logic [3:0] ls_min;
  } time_t;

endpackage : lcd_driver_pkg

// File: rtl/lcd_digit_encode.sv
// lcd_digit_encode
//   Combinational BCD digit to ASCII encoder.
//   Ports:
//     digit  in  4  BCD digit (10..15 are invalid)
//     ascii  out 8  '0'..'9' for 0..9, '!' for invalid codes
module lcd_digit_encode
  import lcd_driver_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  // ASCII '0'..'9' share the upper nibble 4'h3, so a valid digit only
  // needs to be placed in the lower nibble.
  assign ascii = (digit <= 4'd9) ? {ASCII_ZERO[7:4], digit} : ASCII_ERROR;

endmodule : lcd_digit_encode

// File: rtl/lcd_driver_4_digit.sv
// lcd_driver_4_digit
//   Selects one of three 4-digit BCD time sources (alarm, current, key
//   buffer), encodes each digit to ASCII for the LCD and flags when the
//   current time equals the alarm time. All outputs are registered.
//   Ports:
//     clock, reset                     system clock, synchronous active-high reset
//     alarm_time_*  in  4 each         stored alarm time
//     current_time_* in 4 each         running clock time
//     key_*         in  4 each         key-entry buffer
//     show_a        in  1              display alarm time (highest priority)
//     show_current_time in 1           display current time
//     display_*     out 8 each         ASCII code per LCD digit
//     sound_a       out 1              current time equals alarm time
//   Build option:
//     LCD_DRIVER_BLANK_LEADING_ZERO_EN  blank display_ms_hr when that digit is 0
module lcd_driver_4_digit
  import lcd_driver_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] key_ms_hr,
  input  logic [3:0] key_ls_hr,
  input  logic [3:0] key_ms_min,
  input  logic [3:0] key_ls_min,
  input  logic       show_a,
  input  logic       show_current_time,
  output logic [7:0] display_ms_hr,
  output logic [7:0] display_ls_hr,
  output logic [7:0] display_ms_min,
  output logic [7:0] display_ls_min,
  output logic       sound_a
);

  time_t alarm_time;
  time_t current_time;
  time_t key_time;
  time_t shown;

  logic [7:0] enc_ms_hr;
  logic [7:0] enc_ls_hr;
  logic [7:0] enc_ms_min;
  logic [7:0] enc_ls_min;
  logic [7:0] next_ms_hr;
  logic       match;

  assign alarm_time   = '{alarm_time_ms_hr, alarm_time_ls_hr,
                          alarm_time_ms_min, alarm_time_ls_min};
  assign current_time = '{current_time_ms_hr, current_time_ls_hr,
                          current_time_ms_min, current_time_ls_min};
  assign key_time     = '{key_ms_hr, key_ls_hr, key_ms_min, key_ls_min};

  // Source select: alarm beats current time, key buffer is the fallback.
  // NOTE: every branch of an always_comb must assign its outputs; the
  // up-front default guarantees that, so no latch can be inferred.
  always_comb begin
    shown = key_time;
    if (show_a)
      shown = alarm_time;
    else if (show_current_time)
      shown = current_time;
  end

  lcd_digit_encode u_enc_ms_hr  (.digit(shown.ms_hr),  .ascii(enc_ms_hr));
  lcd_digit_encode u_enc_ls_hr  (.digit(shown.ls_hr),  .ascii(enc_ls_hr));
  lcd_digit_encode u_enc_ms_min (.digit(shown.ms_min), .ascii(enc_ms_min));
  lcd_digit_encode u_enc_ls_min (.digit(shown.ls_min), .ascii(enc_ls_min));

`ifdef LCD_DRIVER_BLANK_LEADING_ZERO_EN
  // Show "  5:00" rather than "05:00" for single-digit hours.
  assign next_ms_hr = (shown.ms_hr == 4'd0) ? ASCII_SPACE : enc_ms_hr;
`else
  assign next_ms_hr = enc_ms_hr;
`endif

  // Raw 4-bit compare of all digits, independent of what is displayed.
  assign match = (current_time == alarm_time);

  // NOTE: registered state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      display_ms_hr  <= ASCII_SPACE;
      display_ls_hr  <= ASCII_SPACE;
      display_ms_min <= ASCII_SPACE;
      display_ls_min <= ASCII_SPACE;
      sound_a        <= 1'b0;
    end else begin
      display_ms_hr  <= next_ms_hr;
      display_ls_hr  <= enc_ls_hr;
      display_ms_min <= enc_ms_min;
      display_ls_min <= enc_ls_min;
      sound_a        <= match;
    end
  end

endmodule : lcd_driver_4_digit

// File: tb/tb_lcd_driver_4_digit.sv
// tb_lcd_driver_4_digit
//   Directed self-checking bench for lcd_driver_4_digit. Expected values
//   are hand-computed ASCII codes. Honours LCD_DRIVER_BLANK_LEADING_ZERO_EN.
module tb_lcd_driver_4_digit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min;
  logic [3:0] current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min;
  logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
  logic       show_a, show_current_time;
  logic [7:0] display_ms_hr, display_ls_hr, display_ms_min, display_ls_min;
  logic       sound_a;

  int n_checks = 0;
  int n_passed = 0;

  always #5 clock = ~clock;

  lcd_driver_4_digit dut (
    .clock               (clock),
    .reset               (reset),
    .alarm_time_ms_hr    (alarm_time_ms_hr),
    .alarm_time_ls_hr    (alarm_time_ls_hr),
    .alarm_time_ms_min   (alarm_time_ms_min),
    .alarm_time_ls_min   (alarm_time_ls_min),
    .current_time_ms_hr  (current_time_ms_hr),
    .current_time_ls_hr  (current_time_ls_hr),
    .current_time_ms_min (current_time_ms_min),
    .current_time_ls_min (current_time_ls_min),
    .key_ms_hr           (key_ms_hr),
    .key_ls_hr           (key_ls_hr),
    .key_ms_min          (key_ms_min),
    .key_ls_min          (key_ls_min),
    .show_a              (show_a),
    .show_current_time   (show_current_time),
    .display_ms_hr       (display_ms_hr),
    .display_ls_hr       (display_ls_hr),
    .display_ms_min      (display_ms_min),
    .display_ls_min      (display_ls_min),
    .sound_a             (sound_a)
  );

  task automatic check(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    n_checks++;
    if (actual === expected)
      n_passed++;
    else
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h", tag, actual, expected);
  endtask

  task automatic check_disp(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    check({tag, ".ms_hr"},  display_ms_hr,  e3);
    check({tag, ".ls_hr"},  display_ls_hr,  e2);
    check({tag, ".ms_min"}, display_ms_min, e1);
    check({tag, ".ls_min"}, display_ls_min, e0);
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_alarm(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    {alarm_time_ms_hr, alarm_time_ls_hr, alarm_time_ms_min, alarm_time_ls_min} = {a, b, c, d};
  endtask

  task automatic set_current(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    {current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min} = {a, b, c, d};
  endtask

  task automatic set_key(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
    {key_ms_hr, key_ls_hr, key_ms_min, key_ls_min} = {a, b, c, d};
  endtask

  initial begin
    logic [7:0] exp_blank;

    // Reset with inputs that would otherwise produce digits and a match.
    reset = 1'b1;
    show_a = 1'b1;
    show_current_time = 1'b1;
    set_alarm(4'd1, 4'd2, 4'd3, 4'd4);
    set_current(4'd1, 4'd2, 4'd3, 4'd4);
    set_key(4'd7, 4'd7, 4'd7, 4'd7);
    step();
    step();
    check_disp("reset", 8'h20, 8'h20, 8'h20, 8'h20);
    check("reset.sound_a", {7'b0, sound_a}, 8'h00);

    // Release: key 0000 with both selects low; current/alarm mismatch.
    reset = 1'b0;
    show_a = 1'b0;
    show_current_time = 1'b0;
    set_key(4'd0, 4'd0, 4'd0, 4'd0);
    set_current(4'd0, 4'd0, 4'd0, 4'd0);
    step();
`ifdef LCD_DRIVER_BLANK_LEADING_ZERO_EN
    check_disp("key0", 8'h20, 8'h30, 8'h30, 8'h30);
`else
    check_disp("key0", 8'h30, 8'h30, 8'h30, 8'h30);
`endif
    check("key0.sound_a", {7'b0, sound_a}, 8'h00);

    // Alarm display.
    show_a = 1'b1;
    step();
    check_disp("alarm", 8'h31, 8'h32, 8'h33, 8'h34);
    check("alarm.sound_a", {7'b0, sound_a}, 8'h00);

    // Match: current equals alarm, current time shown.
    show_a = 1'b0;
    show_current_time = 1'b1;
    set_current(4'd1, 4'd2, 4'd3, 4'd4);
    step();
    check_disp("match", 8'h31, 8'h32, 8'h33, 8'h34);
    check("match.sound_a", {7'b0, sound_a}, 8'h01);
    step();
    check("match_hold.sound_a", {7'b0, sound_a}, 8'h01);

    // Mismatch clears at the next edge; output holds until then.
    set_current(4'd5, 4'd6, 4'd7, 4'd8);
    #2;
    check("pre_edge.ms_hr", display_ms_hr, 8'h31);
    step();
    check_disp("mismatch", 8'h35, 8'h36, 8'h37, 8'h38);
    check("mismatch.sound_a", {7'b0, sound_a}, 8'h00);

    // Single-digit difference must still miss the match.
    set_current(4'd1, 4'd2, 4'd3, 4'd5);
    step();
    check("near_miss.sound_a", {7'b0, sound_a}, 8'h00);

    // Non-BCD codes compare raw.
    set_alarm(4'hF, 4'd2, 4'd3, 4'hB);
    set_current(4'hF, 4'd2, 4'd3, 4'hB);
    step();
    check("raw_match.sound_a", {7'b0, sound_a}, 8'h01);
    check_disp("raw_show", 8'h21, 8'h32, 8'h33, 8'h21);

    // Priority: both selects high shows alarm.
    set_alarm(4'd1, 4'd2, 4'd3, 4'd4);
    set_current(4'd5, 4'd6, 4'd7, 4'd8);
    show_a = 1'b1;
    show_current_time = 1'b1;
    step();
    check_disp("priority", 8'h31, 8'h32, 8'h33, 8'h34);

    // Default: key buffer.
    show_a = 1'b0;
    show_current_time = 1'b0;
    set_key(4'd9, 4'd8, 4'd7, 4'd6);
    step();
    check_disp("key9876", 8'h39, 8'h38, 8'h37, 8'h36);

    // Error glyph on ls_min only.
    set_key(4'd0, 4'd0, 4'd0, 4'hA);
    step();
    check("err.ls_min", display_ls_min, 8'h21);
    check("err.ms_min", display_ms_min, 8'h30);

    // Leading-zero option.
`ifdef LCD_DRIVER_BLANK_LEADING_ZERO_EN
    exp_blank = 8'h20;
`else
    exp_blank = 8'h30;
`endif
    set_key(4'd0, 4'd5, 4'd0, 4'd0);
    step();
    check_disp("lead0", exp_blank, 8'h35, 8'h30, 8'h30);

    // Mid-run reset dominates.
    reset = 1'b1;
    step();
    check_disp("reset2", 8'h20, 8'h20, 8'h20, 8'h20);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule : tb_lcd_driver_4_digit
